ddio_tx_scheduler: RTL



---
 rtl/ddio_tx_pkg.sv | 17 +
 rtl/ddio_lane_ser.sv | 37 +++
 rtl/ddio_tx_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ddio_tx_pkg.sv
// Shared constants for the DDIO_OUT transmit scheduler: symbol geometry,
// state codes and the default idle (fill) symbol.
package ddio_tx_pkg;

  localparam int SYM_W  = 10;
  localparam int PHASES = 5;

  localparam logic [SYM_W-1:0] IDLE_SYM_DEF = 10'b1101010100;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 2'd0;
  localparam tx_state_t ST_WARMUP = 2'd1;
  localparam tx_state_t ST_RUN    = 2'd2;
  localparam tx_state_t ST_DRAIN  = 2'd3;

endpackage

// File: rtl/ddio_lane_ser.sv
// One DDIO lane: holds a 10-bit symbol and emits it LSB pair first,
// one (h = even bit, l = odd bit) pair per enabled clock.
module ddio_lane_ser
  import ddio_tx_pkg::*;
(
  input  logic             clk,
  input  logic             aclr,
  input  logic             clk_en,
  input  logic             load,
  input  logic [SYM_W-1:0] sym,
  output logic             dout_h,
  output logic             dout_l
);

  logic [SYM_W-1:0] sh;

  // The pair at sh[1:0] is registered out on the same edge that shifts
  // or reloads, so output lags the phase counter by one cycle.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      sh     <= '0;
      dout_h <= 1'b0;
      dout_l <= 1'b0;
    end else begin
      if (load) begin
        sh <= sym;
      end else if (clk_en) begin
        sh <= sh >> 2;
      end
      if (clk_en) begin
        dout_h <= sh[0];
        dout_l <= sh[1];
      end
    end
  end

endmodule

// File: rtl/ddio_tx_scheduler.sv
// HDMI DDIO_OUT transmit scheduler: warm-up, one-deep group buffer with skid,
// 5-phase symbol serialization on all lanes, idle fill and drain.
module ddio_tx_scheduler
  import ddio_tx_pkg::*;
#(
  parameter int               NUM_LANES  = 8,
  parameter logic [SYM_W-1:0] IDLE_SYM   = IDLE_SYM_DEF,
  parameter int               WARMUP_CYC = 4
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       en,
  input  logic [NUM_LANES*SYM_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [NUM_LANES-1:0]       ddio_datain_h,
  output logic [NUM_LANES-1:0]       ddio_datain_l,
  output logic                       ddio_clk_en,
  output logic                       ddio_oe,
  output logic                       ddio_sclr,
  output logic                       underrun,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int DW = NUM_LANES * SYM_W;

  // s_valid/s_ready: a group transfers on any clk edge where both are high;
  // s_data must stay stable while s_valid is high and s_ready is low.
  tx_state_t       state;
  logic [2:0]      phase;
  logic [7:0]      wcnt;
  logic            full;
  logic [DW-1:0]   hold;
  logic [DW-1:0]   next_grp;
  logic            active;
  logic            last_ph;
  logic            load_next;
  logic            accept;
  logic            start;
  logic            sh_load;
  logic            und_nx;

  assign active  = (state != ST_IDLE);
  assign last_ph = (phase == 3'(PHASES - 1));
  assign start   = (state == ST_IDLE) && en;

  // Real data is only taken into the lanes from the last warm-up symbol
  // onwards; earlier warm-up boundaries keep sending idle and leave the
  // held group in place so nothing is sent while oe is still low.
  assign load_next = last_ph &&
                     ((state == ST_RUN) || ((state == ST_WARMUP) && (wcnt == 8'd0)));
  assign s_ready   = ((state == ST_WARMUP) || (state == ST_RUN)) && (!full || load_next);
  assign accept    = s_valid && s_ready;
  assign sh_load   = start || (active && last_ph);
  assign und_nx    = (state == ST_RUN) && last_ph && !full && !accept;

  // An empty holding reg lets a group arriving on the load edge go straight
  // into the lanes, giving single-cycle latency.
  always_comb begin
    next_grp = {NUM_LANES{IDLE_SYM}};
    if (load_next && full) begin
      next_grp = hold;
    end else if (load_next && accept) begin
      next_grp = s_data;
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state    <= ST_IDLE;
      phase    <= 3'd0;
      wcnt     <= 8'd0;
      full     <= 1'b0;
      hold     <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= und_nx;
      phase    <= (active && !last_ph) ? phase + 3'd1 : 3'd0;

      case (state)
        ST_IDLE: begin
          if (en) begin
            state <= ST_WARMUP;
            wcnt  <= 8'(WARMUP_CYC - 1);
          end
        end
        ST_WARMUP: begin
          if (last_ph) begin
            if (wcnt == 8'd0) begin
              state <= en ? ST_RUN : ST_DRAIN;
            end else begin
              wcnt <= wcnt - 8'd1;
            end
          end
        end
        ST_RUN: begin
          if (!en) begin
            state <= ST_DRAIN;
          end
        end
        default: begin
          if (last_ph) begin
            state <= ST_IDLE;
          end
        end
      endcase

      if (state == ST_DRAIN) begin
        full <= 1'b0;
      end else if (accept && !(load_next && !full)) begin
        hold <= s_data;
        full <= 1'b1;
      end else if (load_next) begin
        full <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    ddio_lane_ser u_ser (
      .clk    (clk),
      .aclr   (aclr),
      .clk_en (active),
      .load   (sh_load),
      .sym    (next_grp[k*SYM_W +: SYM_W]),
      .dout_h (ddio_datain_h[k]),
      .dout_l (ddio_datain_l[k])
    );
  end

  assign ddio_clk_en = active;
  assign ddio_oe     = (state == ST_RUN) || (state == ST_DRAIN);
  assign ddio_sclr   = (state == ST_IDLE) || (state == ST_WARMUP);
  assign busy        = active;
  assign state_dbg   = state;

endmodule
